// File: rtl/pipelined_wallace_mult.sv
// Three-stage pipelined Wallace-tree multiplier, signed or unsigned per beat.
// S1 holds operands, S2 the carry-save pair, S3 the resolved product.
module pipelined_wallace_mult #(
  parameter int WIDTH = 11,
  localparam int PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  op1,
  input  logic [WIDTH-1:0]  op2,
  input  logic              is_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PWIDTH-1:0] product
);

  function automatic int nrows(input int l);
    int n;
    n = WIDTH;
    for (int k = 0; k < l; k++) n = n - n / 3;
    return n;
  endfunction

  function automatic int tree_depth();
    int n;
    int d;
    n = WIDTH;
    d = 0;
    while (n > 2) begin
      n = n - n / 3;
      d++;
    end
    return d;
  endfunction

  localparam int DEPTH = tree_depth();

  logic              v1;
  logic              v2;
  logic              v3;
  logic [WIDTH-1:0]  a1;
  logic [WIDTH-1:0]  b1;
  logic              sgn1;
  logic [PWIDTH-1:0] sum2;
  logic [PWIDTH-1:0] car2;
  logic [PWIDTH-1:0] prod3;
  logic [PWIDTH-1:0] a_ext;
  logic [PWIDTH-1:0] red_sum;
  logic [PWIDTH-1:0] red_car;
  logic              adv;

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign product   = prod3;

  assign a_ext = sgn1 ? {{WIDTH{a1[WIDTH-1]}}, a1}
                      : {{WIDTH{1'b0}}, a1};

  // Level 0 holds the partial products; each later level is 3:2 compressed.
  for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
    localparam int N = nrows(l);
    logic [PWIDTH-1:0] r [N];
    if (l == 0) begin : g_pp
      for (genvar i = 0; i < WIDTH; i++) begin : g_row
        logic [PWIDTH-1:0] m;
        assign m = b1[i] ? (a_ext << i) : '0;
        // In signed mode the multiplier MSB carries negative weight.
        if (i == WIDTH - 1) begin : g_msb
          assign r[i] = sgn1 ? -m : m;
        end else begin : g_lsb
          assign r[i] = m;
        end
      end
    end else begin : g_red
      localparam int M = nrows(l - 1);
      localparam int G = M / 3;
      for (genvar g = 0; g < G; g++) begin : g_csa
        logic [PWIDTH-1:0] x;
        logic [PWIDTH-1:0] y;
        logic [PWIDTH-1:0] z;
        assign x = g_lvl[l-1].r[3*g];
        assign y = g_lvl[l-1].r[3*g+1];
        assign z = g_lvl[l-1].r[3*g+2];
        assign r[2*g]   = x ^ y ^ z;
        assign r[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
      end
      for (genvar k = 3 * G; k < M; k++) begin : g_pass
        assign r[2*G+k-3*G] = g_lvl[l-1].r[k];
      end
    end
  end

  assign red_sum = g_lvl[DEPTH].r[0];
  assign red_car = g_lvl[DEPTH].r[1];

  // Stage data only loads with a valid beat so bubbles keep the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      sgn1  <= 1'b0;
      sum2  <= '0;
      car2  <= '0;
      prod3 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        a1   <= op1;
        b1   <= op2;
        sgn1 <= is_signed;
      end
      if (v1) begin
        sum2 <= red_sum;
        car2 <= red_car;
      end
      if (v2) begin
        prod3 <= sum2 + car2;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_wallace_mult.sv
// Scoreboard bench for pipelined_wallace_mult at WIDTH = 11.
// Driver pushes expected products; a negedge monitor pops and compares.
module tb_pipelined_wallace_mult;

  localparam int W = 11;
  localparam int P = 22;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [P-1:0] p;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [P-1:0] product;

  int           checks = 0;
  int           failures = 0;
  bit           rand_stall = 1'b0;
  logic [P-1:0] exp_q[$];

  vec_t vt[14] = '{
    '{11'h7FF, 11'h7FF, 1'b0, 22'h3FF001},
    '{11'h7FF, 11'h7FF, 1'b1, 22'h000001},
    '{11'h400, 11'h3FF, 1'b1, 22'h300400},
    '{11'h000, 11'h5A5, 1'b0, 22'h000000},
    '{11'h000, 11'h7FF, 1'b1, 22'h000000},
    '{11'h001, 11'h5A5, 1'b0, 22'h0005A5},
    '{11'h7FF, 11'h001, 1'b1, 22'h3FFFFF},
    '{11'h400, 11'h400, 1'b1, 22'h100000},
    '{11'h400, 11'h400, 1'b0, 22'h100000},
    '{11'h002, 11'h003, 1'b0, 22'h000006},
    '{11'h7FF, 11'h002, 1'b1, 22'h3FFFFE},
    '{11'h7FF, 11'h002, 1'b0, 22'h000FFE},
    '{11'h123, 11'h456, 1'b0, 22'h04EDC2},
    '{11'h7FE, 11'h003, 1'b1, 22'h3FFFFA}
  };

  always #5 clk = ~clk;

  pipelined_wallace_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [P-1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic s);
    int x;
    int y;
    x = s ? int'($signed(a)) : int'({1'b0, a});
    y = s ? int'($signed(b)) : int'({1'b0, b});
    return P'(x * y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic [P-1:0] e,
                      output int waits);
    bit rdy;
    waits = 0;
    op1 = a;
    op2 = b;
    is_signed = s;
    in_valid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy) begin
        exp_q.push_back(e);
        in_valid = 1'b0;
        return;
      end
      waits++;
    end
    checks++;
    failures++;
    in_valid = 1'b0;
    $display("FAIL accept_timeout actual=no_accept required=accept");
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", product);
      end else begin
        check("product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int w;
    int lat;
    int stalls;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic s;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(11'h7FF, 11'h7FF, 1'b0, 22'h3FF001, w);
    check("first_accept_waits", 32'(w), 32'd0);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'd3);
    idle(3);

    foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].s, vt[i].p, w);
    idle(4);

    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      send(a, b, s, model(a, b, s), w);
      stalls += w;
    end
    check("stream_stalls", 32'(stalls), 32'd0);
    idle(5);

    send(11'h7FF, 11'h7FF, 1'b0, 22'h3FF001, w);
    send(11'h400, 11'h3FF, 1'b1, 22'h300400, w);
    send(11'h001, 11'h5A5, 1'b0, 22'h0005A5, w);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_product", 32'(product), 32'h3FF001);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    idle(5);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    send(11'h7FF, 11'h7FF, 1'b1, 22'h000001, w);
    send(11'h123, 11'h456, 1'b0, 22'h04EDC2, w);
    send(11'h7FE, 11'h003, 1'b1, 22'h3FFFFA, w);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(out_valid), 32'd0);
      tick();
    end
    send(11'h002, 11'h003, 1'b0, 22'h000006, w);
    check("post_rst_accept", 32'(w), 32'd0);
    idle(4);

    rand_stall = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      send(a, b, s, model(a, b, s), w);
    end
    rand_stall = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_wallace_mult.md
PIPELINED_WALLACE_MULT -- requirements
Module: pipelined_wallace_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 11, meaning operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter PWIDTH, default 2*WIDTH, meaning product width; not overridable.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning the operand beat is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operand beat this cycle.
REQ-007 SHALL have port op1, input, WIDTH, meaning the multiplicand.
REQ-008 SHALL have port op2, input, WIDTH, meaning the multiplier.
REQ-009 SHALL have port is_signed, input, 1, meaning per-beat mode: 0 = unsigned, 1 = two's complement.
REQ-010 SHALL have port out_valid, output, 1, meaning product is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts the product this cycle.
REQ-012 SHALL have port product, output, PWIDTH, meaning the full-width product.

Function
REQ-013 SHALL accept a beat when in_valid && in_ready, and deliver it when out_valid && out_ready.
REQ-014 SHALL be a 3-stage pipeline: S1 registers operands and mode; S2 registers the carry-save sum/carry vectors after full Wallace reduction of all partial products; S3 registers the final carry-propagate sum.
REQ-015 SHALL have a latency of 3 cycles from acceptance to out_valid with no backpressure, and a throughput of 1 beat per cycle.
REQ-016 SHALL generate WIDTH partial products of PWIDTH bits each; reduction uses only 3:2 carry-save adders, with tree depth set by WIDTH through generate logic.
REQ-017 SHALL produce the exact product modulo 2^PWIDTH in unsigned mode.
REQ-018 SHALL produce the exact two's-complement product in signed mode, using Baugh-Wooley or sign-extended partial products; the result never overflows PWIDTH.
REQ-019 SHALL discard the final adder carry-out.
REQ-020 SHALL carry each stage's valid bit alongside its data, so beats with different is_signed values may be interleaved back to back.
REQ-021 SHALL define the global advance enable as adv = !out_valid || out_ready; all stages shift only when adv = 1.
REQ-022 SHALL drive in_ready = adv combinationally, with no combinational path from in_valid to in_ready.
REQ-023 SHALL hold product and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL insert a bubble (stage valid = 0) in S1 when adv = 1 and in_valid = 0; bubbles never produce out_valid.
REQ-025 SHALL load S1 with a new beat in the same cycle that S3 is drained (adv = 1 with the pipeline full), with no lost beat and no duplicated beat.
REQ-026 SHALL keep product free of X in every cycle; a bubble stage holds its previous data.

Reset
REQ-027 SHALL, while rst_n = 0, force all stage valid bits to 0, product to 0 and out_valid to 0, independent of clk.
REQ-028 SHALL drive in_ready to 1 while out_ready = 1 or while the pipeline is empty after reset.
REQ-029 SHALL discard every in-flight beat when reset is asserted mid-operation; no stale product appears after release.
REQ-030 SHALL accept a beat on the first rising edge after rst_n deasserts.

Verification (WIDTH = 11)
REQ-031 Unsigned max: op1 = op2 = 0x7FF, is_signed = 0 -> product = 0x3FF001 with out_valid exactly 3 cycles after acceptance.
REQ-032 Signed: op1 = op2 = 0x7FF, is_signed = 1 -> product = 0x000001; op1 = 0x400, op2 = 0x3FF, is_signed = 1 -> product = 0x300400.
REQ-033 Streaming: 100 back-to-back random beats with mixed mode and out_ready = 1 -> 100 correct products on consecutive cycles, in order.
REQ-034 Backpressure: fill the pipeline, then hold out_ready = 0 for 5 cycles -> product is stable, in_ready = 0, and no beat is lost after release.
REQ-035 Reset mid-flight: assert rst_n = 0 with 3 beats in flight -> out_valid = 0 and product = 0 immediately, with no output after release until a new beat completes 3 cycles later.
REQ-036 Zero/identity: op1 = 0x000 with any op2 -> product = 0; op1 = 0x001, op2 = 0x5A5, is_signed = 0 -> product = 0x0005A5.
REQ-037 Random mode: random stalls and random beats over 10,000 beats at WIDTH in {4, 11, 16} -> product matches the reference model for every beat.
